// File: rtl/sc_io_mmio.sv
// sc_io_mmio: memory-mapped I/O responder for the single-cycle CPU.
//
// Decodes the 0x80-0xFF window and services word loads/stores to the switch,
// key, key-event, LED, 7-segment, timer, timer-compare and timer-status
// registers. Board inputs are double-flop synchronised; keys are debounced
// and produce sticky press events. A free-running timer raises a sticky
// match flag when it equals the compare register.
//
// Ports:
//   clock    - system clock, rising edge
//   resetn   - asynchronous active-low reset
//   addr     - byte address (ALU result); addr[6:2] selects the register
//   datain   - store data
//   we / re  - store / load strobes (wmem / m2reg)
//   io_sel   - high when addr lies in 0x80-0xFF
//   dataout  - combinational load data, zero unless re & io_sel
//   sw_in    - raw slide switches (asynchronous)
//   key_in   - raw push buttons, active-low (asynchronous)
//   led_out  - LED register
//   hex_out  - six 4-bit digits for the 7-segment decoders
//   irq      - OR of all key-event bits and the timer match flag
//
// DEB_CYCLES must be at least 2 and 2**CNT_W must exceed DEB_CYCLES.
module sc_io_mmio #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  input  logic        re,
  output logic        io_sel,
  output logic [31:0] dataout,
  input  logic [9:0]  sw_in,
  input  logic [3:0]  key_in,
  output logic [9:0]  led_out,
  output logic [23:0] hex_out,
  output logic        irq
);

  localparam logic [4:0] RegSw    = 5'd0;
  localparam logic [4:0] RegKey   = 5'd1;
  localparam logic [4:0] RegKevt  = 5'd2;
  localparam logic [4:0] RegLed   = 5'd3;
  localparam logic [4:0] RegHex   = 5'd4;
  localparam logic [4:0] RegTimer = 5'd5;
  localparam logic [4:0] RegTcmp  = 5'd6;
  localparam logic [4:0] RegTstat = 5'd7;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);

  logic [9:0]             sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [3:0]             key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [3:0]             key_db_q, key_db_d;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]             kevt_q, kevt_d;
  logic [9:0]             led_q, led_d;
  logic [23:0]            hex_q, hex_d;
  logic [31:0]            timer_q, timer_d;
  logic [31:0]            tcmp_q, tcmp_d;
  logic                   tstat_q, tstat_d;

  logic [4:0]  idx;
  logic        wr;
  logic [3:0]  key_s;
  logic [3:0]  key_rise;
  logic [31:0] rdata;
  logic        unused_addr;

  assign io_sel      = (addr[31:7] == 25'h1);
  assign idx         = addr[6:2];
  assign wr          = we & io_sel;
  assign unused_addr = ^addr[1:0];

  // Keys are active-low on the board; after sync, 1 means pressed.
  assign key_s = ~key_s2_q;

  always_comb begin
    sw_s1_d  = sw_in;
    sw_s2_d  = sw_s1_q;
    key_s1_d = key_in;
    key_s2_d = key_s1_q;

    key_db_d = key_db_q;
    cnt_d    = '0;
    for (int i = 0; i < 4; i++) begin
      if (key_s[i] != key_db_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          key_db_d[i] = ~key_db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    key_rise = key_db_d & ~key_db_q;

    // W1C clear first, then set, so a coincident event wins.
    kevt_d = kevt_q;
    if (wr && idx == RegKevt) kevt_d = kevt_d & ~datain[3:0];
    kevt_d = kevt_d | key_rise;

    led_d = led_q;
    if (wr && idx == RegLed) led_d = datain[9:0];

    hex_d = hex_q;
    if (wr && idx == RegHex) hex_d = datain[23:0];

    timer_d = timer_q + 32'd1;
    if (wr && idx == RegTimer) timer_d = datain;

    tcmp_d = tcmp_q;
    if (wr && idx == RegTcmp) tcmp_d = datain;

    // Match compares the pre-update timer against the current compare value.
    tstat_d = tstat_q;
    if (wr && idx == RegTstat && datain[0]) tstat_d = 1'b0;
    if (timer_q == tcmp_q) tstat_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      key_db_q <= '0;
      cnt_q    <= '0;
      kevt_q   <= '0;
      led_q    <= '0;
      hex_q    <= '0;
      timer_q  <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      tstat_q  <= 1'b0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
      kevt_q   <= kevt_d;
      led_q    <= led_d;
      hex_q    <= hex_d;
      timer_q  <= timer_d;
      tcmp_q   <= tcmp_d;
      tstat_q  <= tstat_d;
    end
  end

  // Read mux uses only registered state, so a same-cycle write returns old data.
  always_comb begin
    rdata = '0;
    case (idx)
      RegSw:    rdata = {22'b0, sw_s2_q};
      RegKey:   rdata = {28'b0, key_db_q};
      RegKevt:  rdata = {28'b0, kevt_q};
      RegLed:   rdata = {22'b0, led_q};
      RegHex:   rdata = {8'b0, hex_q};
      RegTimer: rdata = timer_q;
      RegTcmp:  rdata = tcmp_q;
      RegTstat: rdata = {31'b0, tstat_q};
      default:  rdata = '0;
    endcase
  end

  assign dataout = (re & io_sel) ? rdata : 32'h0;
  assign led_out = led_q;
  assign hex_out = hex_q;
  assign irq     = (|kevt_q) | tstat_q;

endmodule

// File: tb/tb_sc_io_mmio.sv
// Directed self-checking bench for sc_io_mmio.
module tb_sc_io_mmio;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic        re;
  logic        io_sel;
  logic [31:0] dataout;
  logic [9:0]  sw_in;
  logic [3:0]  key_in;
  logic [9:0]  led_out;
  logic [23:0] hex_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  sc_io_mmio #(
    .DEB_CYCLES(16),
    .CNT_W     (5)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .addr   (addr),
    .datain (datain),
    .we     (we),
    .re     (re),
    .io_sel (io_sel),
    .dataout(dataout),
    .sw_in  (sw_in),
    .key_in (key_in),
    .led_out(led_out),
    .hex_out(hex_out),
    .irq    (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; leave time 1 unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    datain = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    re   = 1'b1;
    #1;
    d    = dataout;
    re   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    resetn = 1'b0;
    addr   = '0;
    datain = '0;
    we     = 1'b0;
    re     = 1'b0;
    sw_in  = '0;
    key_in = 4'hF;
    ticks(3);
    resetn = 1'b1;

    // Reset state and decode
    rd_check("tcmp_reset", 32'h98, 32'hFFFF_FFFF);
    rd_check("led_reset", 32'h8C, 32'h0);
    check_eq("irq_reset", {31'b0, irq}, 32'h0);
    check_eq("hex_reset", {8'b0, hex_out}, 32'h0);
    addr = 32'h7C; #1;
    check_eq("io_sel_7c", {31'b0, io_sel}, 32'h0);
    addr = 32'h80; #1;
    check_eq("io_sel_80", {31'b0, io_sel}, 32'h1);
    addr = 32'hFF; #1;
    check_eq("io_sel_ff", {31'b0, io_sel}, 32'h1);
    addr = 32'h100; #1;
    check_eq("io_sel_100", {31'b0, io_sel}, 32'h0);

    // LED / HEX write and readback
    wr(32'h8C, 32'hFFFF_F2A5);
    check_eq("led_out", {22'b0, led_out}, 32'h2A5);
    rd_check("led_read", 32'h8C, 32'h0000_02A5);
    rd_check("led_read_bytealias", 32'h8F, 32'h0000_02A5);
    // Same-cycle read and write returns the old value
    addr = 32'h8C; datain = 32'h1; we = 1'b1; re = 1'b1; #1;
    check_eq("rw_collide_old", dataout, 32'h0000_02A5);
    tick();
    we = 1'b0; re = 1'b0;
    check_eq("rw_collide_new", {22'b0, led_out}, 32'h1);
    wr(32'h90, 32'hAB12_3456);
    check_eq("hex_out", {8'b0, hex_out}, 32'h0012_3456);
    rd_check("hex_read", 32'h90, 32'h0012_3456);
    wr(32'h80, 32'h3FF);
    rd_check("sw_ro", 32'h80, 32'h0);
    rd_check("unmapped_a0", 32'hA0, 32'h0);
    rd_check("outside_window", 32'h10C, 32'h0);
    wr(32'h10C, 32'h3);  // outside window: no effect on LED
    check_eq("led_nowrite_outside", {22'b0, led_out}, 32'h1);

    // Switch synchroniser latency
    sw_in = 10'h155;
    tick();
    rd_check("sw_1cyc", 32'h80, 32'h0);
    tick();
    rd_check("sw_2cyc", 32'h80, 32'h155);

    // Bounces shorter than the debounce window are ignored
    key_in = 4'b1101; ticks(5);
    key_in = 4'b1111; ticks(3);
    key_in = 4'b1101; ticks(8);
    key_in = 4'b1111; ticks(3);
    key_in = 4'b1101; ticks(12);
    key_in = 4'b1111;
    rd_check("bounce_key", 32'h84, 32'h0);
    ticks(20);
    rd_check("bounce_key_later", 32'h84, 32'h0);
    rd_check("bounce_kevt", 32'h88, 32'h0);

    // Held press: KEY changes after 2 + 16 edges
    key_in = 4'b1101;
    ticks(17);
    rd_check("key_17", 32'h84, 32'h0);
    tick();
    rd_check("key_18", 32'h84, 32'h2);
    rd_check("kevt_set", 32'h88, 32'h2);
    check_eq("irq_kevt", {31'b0, irq}, 32'h1);
    wr(32'h88, 32'h2);
    rd_check("kevt_w1c", 32'h88, 32'h0);
    check_eq("irq_clear", {31'b0, irq}, 32'h0);

    // Release, then clear on the same edge as a new press: set wins
    key_in = 4'b1111;
    ticks(20);
    rd_check("key_released", 32'h84, 32'h0);
    rd_check("kevt_no_release_evt", 32'h88, 32'h0);
    key_in = 4'b1101;
    ticks(17);
    wr(32'h88, 32'h2);
    rd_check("kevt_set_wins", 32'h88, 32'h2);
    wr(32'h88, 32'hF);
    rd_check("kevt_cleared", 32'h88, 32'h0);
    check_eq("irq_before_timer", {31'b0, irq}, 32'h0);

    // Timer wrap and compare match
    wr(32'h98, 32'h0000_0001);
    wr(32'h94, 32'hFFFF_FFFE);
    rd_check("timer_load", 32'h94, 32'hFFFF_FFFE);
    tick();
    rd_check("timer_ffff", 32'h94, 32'hFFFF_FFFF);
    tick();
    rd_check("timer_wrap", 32'h94, 32'h0);
    tick();
    rd_check("timer_one", 32'h94, 32'h1);
    rd_check("tstat_pre", 32'h9C, 32'h0);
    tick();
    rd_check("tstat_match", 32'h9C, 32'h1);
    check_eq("irq_tstat", {31'b0, irq}, 32'h1);
    wr(32'h9C, 32'h1);
    rd_check("tstat_w1c", 32'h9C, 32'h0);
    check_eq("irq_tstat_clear", {31'b0, irq}, 32'h0);

    // Asynchronous reset mid-debounce with LED set
    wr(32'h8C, 32'h3FF);
    check_eq("led_3ff", {22'b0, led_out}, 32'h3FF);
    key_in = 4'b1100;
    ticks(8);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_led", {22'b0, led_out}, 32'h0);
    check_eq("rst_hex", {8'b0, hex_out}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    rd_check("rst_key", 32'h84, 32'h0);
    rd_check("rst_sw", 32'h80, 32'h0);
    rd_check("rst_timer", 32'h94, 32'h0);
    rd_check("rst_tcmp", 32'h98, 32'hFFFF_FFFF);
    ticks(2);
    resetn = 1'b1;
    ticks(17);
    rd_check("post_rst_key_17", 32'h84, 32'h0);
    tick();
    rd_check("post_rst_key_18", 32'h84, 32'h3);
    rd_check("post_rst_kevt", 32'h88, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
